// File: rtl/a_code_checker.sv
// ============================================================================
// Module      : a_code_checker
// Description : Keypad front end of the digital lock. Collects a BCD code,
//               checks it against the stored code, and runs the lockout timer.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module a_code_checker #(
    parameter int                    N_DIGITS       = 4,
    parameter logic [4*N_DIGITS-1:0] DEFAULT_CODE   = 16'h1234,
    parameter int                    TIMEOUT_CYCLES = 50_000_000,
    parameter int                    LOCKOUT_CYCLES = 100_000_000
) (
    input  logic                            clk_i,
    input  logic                            gen_rst_i,
    input  logic                            digit_valid_i,
    input  logic [3:0]                      digit_i,
    input  logic                            lock_stop_i,
    input  logic                            code_we_i,
    input  logic [4*N_DIGITS-1:0]           code_in_i,
    output logic                            err_pulse_o,
    output logic                            ok_pulse_o,
    output logic                            release_pulse_o,
    output logic                            unlocked_o,
    output logic                            lockout_o,
    output logic [$clog2(N_DIGITS+1)-1:0]   digits_entered_o
);

    localparam int CODE_W = 4 * N_DIGITS;
    localparam int CNT_W  = $clog2(N_DIGITS + 1);
    localparam int TMO_W  = $clog2(TIMEOUT_CYCLES + 1);
    localparam int LCK_W  = $clog2(LOCKOUT_CYCLES + 1);

    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(N_DIGITS - 1);
    localparam logic [CNT_W-1:0] CNT_FULL  = CNT_W'(N_DIGITS);
    localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'(TIMEOUT_CYCLES - 1);
    localparam logic [LCK_W-1:0] LCK_LAST  = LCK_W'(LOCKOUT_CYCLES - 1);

    localparam logic [3:0] KEY_CLEAR  = 4'hA;
    localparam logic [3:0] KEY_RELOCK = 4'hB;

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_ENTRY    = 3'd1;
    localparam logic [2:0] S_CHECK    = 3'd2;
    localparam logic [2:0] S_UNLOCKED = 3'd3;
    localparam logic [2:0] S_LOCKOUT  = 3'd4;
    localparam logic [2:0] S_REL_WAIT = 3'd5;

    logic [2:0]        state_q,    state_d;
    logic [CODE_W-1:0] buf_q,      buf_d;
    logic [CNT_W-1:0]  cnt_q,      cnt_d;
    logic [TMO_W-1:0]  tmo_q,      tmo_d;
    logic [LCK_W-1:0]  lck_q,      lck_d;
    logic [CODE_W-1:0] code_q,     code_d;
    logic              ok_q,       ok_d;
    logic              err_q,      err_d;
    logic              rel_q,      rel_d;
    logic              unlocked_q;
    logic              lockout_q;

    logic              w_num;
    logic              w_clear;
    logic              w_relock;
    logic [CODE_W-1:0] w_shifted;
    logic [CNT_W-1:0]  w_cnt_inc;

    assign w_num     = digit_valid_i && (digit_i <= 4'd9);
    assign w_clear   = digit_valid_i && (digit_i == KEY_CLEAR);
    assign w_relock  = digit_valid_i && (digit_i == KEY_RELOCK);
    assign w_shifted = (buf_q << 4) | CODE_W'(digit_i);
    assign w_cnt_inc = (cnt_q == CNT_FULL) ? cnt_q : cnt_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        buf_d   = buf_q;
        cnt_d   = cnt_q;
        tmo_d   = tmo_q;
        lck_d   = lck_q;
        code_d  = code_q;
        ok_d    = 1'b0;
        err_d   = 1'b0;
        rel_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                // A pending lockout request wins over a digit in the same cycle
                if (lock_stop_i) begin
                    state_d = S_LOCKOUT;
                    buf_d   = '0;
                    cnt_d   = '0;
                    lck_d   = '0;
                end else if (w_num) begin
                    state_d = S_ENTRY;
                    buf_d   = w_shifted;
                    cnt_d   = CNT_W'(1);
                    tmo_d   = '0;
                end
            end

            S_ENTRY: begin
                if (lock_stop_i) begin
                    state_d = S_LOCKOUT;
                    buf_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                    lck_d   = '0;
                end else if (w_num) begin
                    buf_d = w_shifted;
                    cnt_d = w_cnt_inc;
                    tmo_d = '0;
                    if (cnt_q == CNT_LAST) begin
                        state_d = S_CHECK;
                    end
                end else if (w_clear || (tmo_q >= TMO_LAST)) begin
                    state_d = S_IDLE;
                    buf_d   = '0;
                    cnt_d   = '0;
                    tmo_d   = '0;
                end else begin
                    tmo_d = tmo_q + TMO_W'(1);
                end
            end

            S_CHECK: begin
                if (buf_q == code_q) begin
                    ok_d    = 1'b1;
                    state_d = S_UNLOCKED;
                end else begin
                    err_d   = 1'b1;
                    state_d = S_IDLE;
                end
                buf_d = '0;
                cnt_d = '0;
            end

            S_UNLOCKED: begin
                if (code_we_i) begin
                    code_d = code_in_i;
                end
                if (w_relock) begin
                    state_d = S_IDLE;
                end
            end

            S_LOCKOUT: begin
                if (lck_q >= LCK_LAST) begin
                    rel_d   = 1'b1;
                    lck_d   = '0;
                    state_d = S_REL_WAIT;
                end else begin
                    lck_d = lck_q + LCK_W'(1);
                end
            end

            S_REL_WAIT: begin
                if (!lock_stop_i) begin
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
                buf_d   = '0;
                cnt_d   = '0;
                tmo_d   = '0;
                lck_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or posedge gen_rst_i) begin
        if (gen_rst_i) begin
            state_q    <= S_IDLE;
            buf_q      <= '0;
            cnt_q      <= '0;
            tmo_q      <= '0;
            lck_q      <= '0;
            code_q     <= DEFAULT_CODE;
            ok_q       <= 1'b0;
            err_q      <= 1'b0;
            rel_q      <= 1'b0;
            unlocked_q <= 1'b0;
            lockout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            buf_q      <= buf_d;
            cnt_q      <= cnt_d;
            tmo_q      <= tmo_d;
            lck_q      <= lck_d;
            code_q     <= code_d;
            ok_q       <= ok_d;
            err_q      <= err_d;
            rel_q      <= rel_d;
            // Status flags track the next state so they line up with the pulses
            unlocked_q <= (state_d == S_UNLOCKED);
            lockout_q  <= (state_d == S_LOCKOUT) || (state_d == S_REL_WAIT);
        end
    end

    assign err_pulse_o      = err_q;
    assign ok_pulse_o       = ok_q;
    assign release_pulse_o  = rel_q;
    assign unlocked_o       = unlocked_q;
    assign lockout_o        = lockout_q;
    assign digits_entered_o = cnt_q;

endmodule

`default_nettype wire

// File: tb/tb_a_code_checker.sv
// ============================================================================
// Module      : tb_a_code_checker
// Description : Directed bench for a_code_checker with an error processor model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_a_code_checker;

    logic        clk_i = 1'b0;
    logic        gen_rst_i;
    logic        digit_valid_i;
    logic [3:0]  digit_i;
    logic        lock_stop_i;
    logic        code_we_i;
    logic [15:0] code_in_i;
    logic        err_pulse_o;
    logic        ok_pulse_o;
    logic        release_pulse_o;
    logic        unlocked_o;
    logic        lockout_o;
    logic [2:0]  digits_entered_o;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    int n_ok  = 0;
    int n_err = 0;
    int n_rel = 0;
    int ecount = 0;
    int t0;
    int snap;

    a_code_checker #(
        .N_DIGITS       (4),
        .DEFAULT_CODE   (16'h1234),
        .TIMEOUT_CYCLES (8),
        .LOCKOUT_CYCLES (16)
    ) dut (
        .clk_i            (clk_i),
        .gen_rst_i        (gen_rst_i),
        .digit_valid_i    (digit_valid_i),
        .digit_i          (digit_i),
        .lock_stop_i      (lock_stop_i),
        .code_we_i        (code_we_i),
        .code_in_i        (code_in_i),
        .err_pulse_o      (err_pulse_o),
        .ok_pulse_o       (ok_pulse_o),
        .release_pulse_o  (release_pulse_o),
        .unlocked_o       (unlocked_o),
        .lockout_o        (lockout_o),
        .digits_entered_o (digits_entered_o)
    );

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) cyc <= cyc + 1;

    // Error processor: three errors raise lock_stop, ok clears the tally,
    // release drops lock_stop.
    always @(negedge clk_i) begin
        if (gen_rst_i) begin
            lock_stop_i = 1'b0;
            ecount      = 0;
        end else begin
            if (err_pulse_o) begin
                n_err++;
                ecount++;
                if (ecount == 3) begin
                    lock_stop_i = 1'b1;
                    ecount      = 0;
                end
            end
            if (ok_pulse_o) begin
                n_ok++;
                ecount = 0;
            end
            if (release_pulse_o) begin
                n_rel++;
                lock_stop_i = 1'b0;
            end
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic press(input logic [3:0] d);
        @(negedge clk_i);
        digit_valid_i = 1'b1;
        digit_i       = d;
        @(negedge clk_i);
        digit_valid_i = 1'b0;
        digit_i       = 4'h0;
    endtask

    task automatic enter(input logic [15:0] code);
        press(code[15:12]);
        press(code[11:8]);
        press(code[7:4]);
        press(code[3:0]);
    endtask

    task automatic expect_result(input string tag, input logic exp_ok, input logic exp_err);
        chk({tag, "_pre_ok"}, 32'(ok_pulse_o), 32'(0));
        chk({tag, "_pre_err"}, 32'(err_pulse_o), 32'(0));
        @(posedge clk_i); #1;
        chk({tag, "_ok"}, 32'(ok_pulse_o), 32'(exp_ok));
        chk({tag, "_err"}, 32'(err_pulse_o), 32'(exp_err));
        @(posedge clk_i); #1;
        chk({tag, "_post_ok"}, 32'(ok_pulse_o), 32'(0));
        chk({tag, "_post_err"}, 32'(err_pulse_o), 32'(0));
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_ok"}, 32'(ok_pulse_o), 32'(0));
        chk({tag, "_err"}, 32'(err_pulse_o), 32'(0));
        chk({tag, "_rel"}, 32'(release_pulse_o), 32'(0));
        chk({tag, "_unl"}, 32'(unlocked_o), 32'(0));
        chk({tag, "_lko"}, 32'(lockout_o), 32'(0));
        chk({tag, "_dig"}, 32'(digits_entered_o), 32'(0));
    endtask

    task automatic do_reset();
        @(negedge clk_i);
        gen_rst_i = 1'b1;
        repeat (2) @(negedge clk_i);
        gen_rst_i = 1'b0;
    endtask

    initial begin
        gen_rst_i     = 1'b1;
        digit_valid_i = 1'b0;
        digit_i       = 4'h0;
        lock_stop_i   = 1'b0;
        code_we_i     = 1'b0;
        code_in_i     = 16'h0;
        repeat (3) @(posedge clk_i);
        #1;
        chk_all_zero("reset");
        @(negedge clk_i);
        gen_rst_i = 1'b0;

        // 1: correct default code, partial count visible on the way
        press(4'h1); press(4'h2); press(4'h3);
        chk("t1_dig3", 32'(digits_entered_o), 32'(3));
        press(4'h4);
        expect_result("t1", 1'b1, 1'b0);
        chk("t1_unl", 32'(unlocked_o), 32'(1));
        chk("t1_dig0", 32'(digits_entered_o), 32'(0));

        // 2: relock, then wrong code
        press(4'hB);
        chk("t2_relock", 32'(unlocked_o), 32'(0));
        enter(16'h1235);
        expect_result("t2", 1'b0, 1'b1);
        chk("t2_unl", 32'(unlocked_o), 32'(0));
        chk("t2_lko", 32'(lockout_o), 32'(0));

        // 3: three wrong codes trigger lockout
        do_reset();
        enter(16'h1235); expect_result("t3a", 1'b0, 1'b1);
        enter(16'h0000); expect_result("t3b", 1'b0, 1'b1);
        chk("t3_not_yet", 32'(lockout_o), 32'(0));
        enter(16'h9999); expect_result("t3c", 1'b0, 1'b1);
        chk("t3_lko", 32'(lockout_o), 32'(1));
        t0   = cyc;
        snap = n_ok;
        enter(16'h1234);
        chk("t3_keys_ok", 32'(n_ok), 32'(snap));
        chk("t3_keys_dig", 32'(digits_entered_o), 32'(0));
        for (int i = 0; i < 40; i++) begin
            if (release_pulse_o) break;
            @(posedge clk_i); #1;
        end
        chk("t3_rel_seen", 32'(release_pulse_o), 32'(1));
        chk("t3_rel_time", 32'(cyc - t0), 32'(16));
        chk("t3_relwait", 32'(lockout_o), 32'(1));
        @(posedge clk_i); #1;
        chk("t3_rel_width", 32'(release_pulse_o), 32'(0));
        chk("t3_idle", 32'(lockout_o), 32'(0));
        enter(16'h1234);
        expect_result("t3_ok", 1'b1, 1'b0);

        // 4: inter-digit timeout, then clear key
        press(4'hB);
        snap = n_err;
        press(4'h1); press(4'h2);
        chk("t4_dig2", 32'(digits_entered_o), 32'(2));
        repeat (7) @(posedge clk_i);
        #1;
        chk("t4_before_tmo", 32'(digits_entered_o), 32'(2));
        @(posedge clk_i); #1;
        chk("t4_after_tmo", 32'(digits_entered_o), 32'(0));
        repeat (2) @(posedge clk_i);
        #1;
        chk("t4_no_err", 32'(n_err), 32'(snap));
        press(4'h1); press(4'h2); press(4'hA);
        chk("t4_clear", 32'(digits_entered_o), 32'(0));
        snap = n_ok;
        enter(16'h1234);
        expect_result("t4_ok", 1'b1, 1'b0);
        chk("t4_single", 32'(n_ok), 32'(snap + 1));

        // 5: code change while unlocked
        @(negedge clk_i);
        code_we_i = 1'b1;
        code_in_i = 16'h9876;
        @(negedge clk_i);
        code_we_i = 1'b0;
        chk("t5_still_unl", 32'(unlocked_o), 32'(1));
        press(4'hB);
        chk("t5_relock", 32'(unlocked_o), 32'(0));
        enter(16'h1234);
        expect_result("t5_old", 1'b0, 1'b1);
        enter(16'h9876);
        expect_result("t5_new", 1'b1, 1'b0);
        @(negedge clk_i);
        code_we_i     = 1'b1;
        code_in_i     = 16'h5555;
        digit_valid_i = 1'b1;
        digit_i       = 4'hB;
        @(negedge clk_i);
        code_we_i     = 1'b0;
        digit_valid_i = 1'b0;
        chk("t5_we_relock", 32'(unlocked_o), 32'(0));
        @(negedge clk_i);
        code_we_i = 1'b1;
        code_in_i = 16'h1111;
        @(negedge clk_i);
        code_we_i = 1'b0;
        enter(16'h5555);
        expect_result("t5_same_cycle", 1'b1, 1'b0);

        // 6: asynchronous reset during ENTRY and during LOCKOUT
        press(4'hB);
        press(4'h1); press(4'h2);
        @(negedge clk_i);
        gen_rst_i = 1'b1;
        #1;
        chk_all_zero("t6_entry");
        @(negedge clk_i);
        @(negedge clk_i);
        gen_rst_i = 1'b0;
        enter(16'h1234);
        expect_result("t6_default", 1'b1, 1'b0);
        press(4'hB);
        enter(16'h1111); expect_result("t6a", 1'b0, 1'b1);
        enter(16'h2222); expect_result("t6b", 1'b0, 1'b1);
        enter(16'h3333); expect_result("t6c", 1'b0, 1'b1);
        chk("t6_lko", 32'(lockout_o), 32'(1));
        repeat (5) @(posedge clk_i);
        @(negedge clk_i);
        gen_rst_i = 1'b1;
        #1;
        chk_all_zero("t6_lockout");
        @(negedge clk_i);
        @(negedge clk_i);
        gen_rst_i = 1'b0;
        snap = n_rel;
        repeat (20) @(posedge clk_i);
        #1;
        chk("t6_no_rel", 32'(n_rel), 32'(snap));
        chk("t6_lko_off", 32'(lockout_o), 32'(0));
        enter(16'h1234);
        expect_result("t6_after", 1'b1, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
